// File: rtl/exec_stage_pipe_pkg.sv
// exec_stage_pipe_pkg
//   Shared definitions for the registered execute stage: ALU control codes,
//   R-type opcode constants, FSM state encoding and the ALU control decode.
package exec_stage_pipe_pkg;

   typedef enum logic [3:0] {
      ALUC_AND   = 4'b0000,
      ALUC_ORR   = 4'b0001,
      ALUC_ADD   = 4'b0010,
      ALUC_SUB   = 4'b0110,
      ALUC_PASSB = 4'b0111,
      ALUC_MUL   = 4'b1111
   } alu_ctrl_t;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_MUL = 11'b10011011000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // alu_op 11 is reserved and behaves as add. Without a multiplier the MUL
   // opcode also collapses to add.
   function automatic alu_ctrl_t alu_decode(input logic [1:0]  alu_op,
                                            input logic [10:0] opcode,
                                            input logic        mul_en);
      alu_ctrl_t c;
      c = ALUC_ADD;
      case (alu_op)
         ALUOP_PASSB: c = ALUC_PASSB;
         ALUOP_RTYPE: begin
            case (opcode)
               OPC_ADD: c = ALUC_ADD;
               OPC_SUB: c = ALUC_SUB;
               OPC_AND: c = ALUC_AND;
               OPC_ORR: c = ALUC_ORR;
               OPC_MUL: c = mul_en ? ALUC_MUL : ALUC_ADD;
               default: c = ALUC_ADD;
            endcase
         end
         default: c = ALUC_ADD;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/exec_stage_pipe_iter_mul.sv
// iter_mul
//   Iterative shift-add multiplier, MUL_BITS multiplier bits per cycle,
//   WIDTH/MUL_BITS steps. Returns the low WIDTH bits of the product.
// Ports:
//   clk, reset   clock, synchronous active-low reset (aborts any multiply)
//   start        load a/b and begin (ignored handshake-wise while busy)
//   a, b         multiplicand, multiplier
//   ack          consumer takes the product this cycle (only honoured on done)
//   busy         a multiply is in progress or parked waiting for ack
//   done         final step is being retired; product is valid this cycle
//   product      acc + current partial product (combinational)
module iter_mul #(
   parameter int WIDTH    = 64,
   parameter int MUL_BITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / MUL_BITS;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] partial;
   logic [CW-1:0]    count;

   assign partial = mcand * WIDTH'(mplier[MUL_BITS-1:0]);
   assign product = acc + partial;
   assign done    = busy && (count == '0);

   // When the result is not taken on the last step, stepping continues with
   // the counter pinned at zero. The multiplier has been shifted out to zero
   // by then, so every further partial is zero and the product holds.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start && !busy) begin
         busy   <= 1'b1;
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         count  <= LAST_STEP;
      end else if (busy) begin
         if (done && ack) begin
            busy <= 1'b0;
            acc  <= '0;
         end else begin
            acc    <= product;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            if (count != '0) begin
               count <= count - CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe
//   Registered execute stage between ID/EX and EX/MEM with valid/ready on
//   both sides. Computes branch target, ALU result and zero flag into a
//   single output slot; MUL runs on an iterative multiplier and stalls
//   upstream for WIDTH/MUL_BITS cycles.
//   WIDTH must be >= 8 and a multiple of MUL_BITS.
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   in_valid / in_ready     upstream handshake
//   cur_pc, read_data1/2,   instruction operands, sampled on accept only
//   sign_extended_output,
//   alu_op, opcode, alu_src
//   out_valid / out_ready   downstream handshake for the EX/MEM slot
//   branch_target, alu_result, zero, store_data   registered slot contents
//
// state   | meaning
// ST_IDLE | accepting; non-MUL ops land in the slot next edge
// ST_MUL  | multiply in progress (or finished, waiting for a free slot)
module exec_stage_pipe
   import exec_stage_pipe_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int MUL_BITS = 4,
   parameter int MUL_EN   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] cur_pc,
   input  logic [WIDTH-1:0] read_data1,
   input  logic [WIDTH-1:0] read_data2,
   input  logic [WIDTH-1:0] sign_extended_output,
   input  logic [1:0]       alu_op,
   input  logic [10:0]      opcode,
   input  logic             alu_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic [WIDTH-1:0] store_data
);

   state_t           state;
   alu_ctrl_t        alu_ctrl;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] target_now;
   logic [WIDTH-1:0] pend_target;
   logic [WIDTH-1:0] pend_store;
   logic [WIDTH-1:0] mul_product;
   logic             slot_free;
   logic             accept;
   logic             is_mul;
   logic             mul_start;
   logic             mul_ack;
   logic             mul_busy;
   logic             mul_done;

   assign slot_free  = !out_valid || out_ready;
   // Held low during reset so nothing is considered accepted while the
   // stage is being cleared.
   assign in_ready   = reset && (state == ST_IDLE) && slot_free;
   assign accept     = in_valid && in_ready;
   assign op_b       = alu_src ? sign_extended_output : read_data2;
   assign target_now = cur_pc + (sign_extended_output << 2);
   assign alu_ctrl   = alu_decode(alu_op, opcode, MUL_EN != 0);
   assign is_mul     = (alu_ctrl == ALUC_MUL);
   assign mul_start  = accept && is_mul;
   assign mul_ack    = (state == ST_MUL) && mul_busy && mul_done && slot_free;

   always_comb begin
      alu_out = read_data1 + op_b;
      case (alu_ctrl)
         ALUC_AND:   alu_out = read_data1 & op_b;
         ALUC_ORR:   alu_out = read_data1 | op_b;
         ALUC_SUB:   alu_out = read_data1 - op_b;
         ALUC_PASSB: alu_out = op_b;
         default:    alu_out = read_data1 + op_b;
      endcase
   end

   if (MUL_EN != 0) begin : g_mul
      iter_mul #(
         .WIDTH    (WIDTH),
         .MUL_BITS (MUL_BITS)
      ) u_iter_mul (
         .clk     (clk),
         .reset   (reset),
         .start   (mul_start),
         .a       (read_data1),
         .b       (op_b),
         .ack     (mul_ack),
         .busy    (mul_busy),
         .done    (mul_done),
         .product (mul_product)
      );
   end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         out_valid     <= 1'b0;
         branch_target <= '0;
         alu_result    <= '0;
         zero          <= 1'b1;
         store_data    <= '0;
         pend_target   <= '0;
         pend_store    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && is_mul) begin
                  // Accept implies the slot was empty or is being consumed,
                  // so it is empty for the whole multiply.
                  state       <= ST_MUL;
                  pend_target <= target_now;
                  pend_store  <= read_data2;
                  out_valid   <= 1'b0;
               end else if (accept) begin
                  out_valid     <= 1'b1;
                  branch_target <= target_now;
                  alu_result    <= alu_out;
                  zero          <= (alu_out == '0);
                  store_data    <= read_data2;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (mul_ack) begin
                  state         <= ST_IDLE;
                  out_valid     <= 1'b1;
                  branch_target <= pend_target;
                  alu_result    <= mul_product;
                  zero          <= (mul_product == '0);
                  store_data    <= pend_store;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stage_pipe.sv
module tb_exec_stage_pipe;

   localparam int W = 64;
   localparam logic [10:0] O_ADD = 11'b10001011000;
   localparam logic [10:0] O_SUB = 11'b11001011000;
   localparam logic [10:0] O_AND = 11'b10001010000;
   localparam logic [10:0] O_ORR = 11'b10101010000;
   localparam logic [10:0] O_MUL = 11'b10011011000;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  cur_pc;
   logic [W-1:0]  read_data1;
   logic [W-1:0]  read_data2;
   logic [W-1:0]  sign_extended_output;
   logic [1:0]    alu_op;
   logic [10:0]   opcode;
   logic          alu_src;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  branch_target;
   logic [W-1:0]  alu_result;
   logic          zero;
   logic [W-1:0]  store_data;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] bt;
      logic [W-1:0] sd;
      bit           is_mul;
   } exp_t;

   exec_stage_pipe #(.WIDTH(W), .MUL_BITS(4), .MUL_EN(1)) dut (
      .clk                  (clk),
      .reset                (reset),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .cur_pc               (cur_pc),
      .read_data1           (read_data1),
      .read_data2           (read_data2),
      .sign_extended_output (sign_extended_output),
      .alu_op               (alu_op),
      .opcode               (opcode),
      .alu_src              (alu_src),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .branch_target        (branch_target),
      .alu_result           (alu_result),
      .zero                 (zero),
      .store_data           (store_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Behavioural reference: what the instruction means, not how it is built.
   function automatic logic [W-1:0] model_result(input logic [1:0] aop, input logic [10:0] opc,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
      if (aop == 2'b01) return b;
      if (aop == 2'b10) begin
         if (opc == O_SUB) return a - b;
         if (opc == O_AND) return a & b;
         if (opc == O_ORR) return a | b;
         if (opc == O_MUL) return a * b;
      end
      return a + b;
   endfunction

   function automatic logic [W-1:0] model_target(input logic [W-1:0] pc, input logic [W-1:0] im);
      return pc + im * 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] aop, input logic [10:0] opc,
                        input logic src, input logic [W-1:0] pc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] im);
      in_valid             = v;
      alu_op               = aop;
      opcode               = opc;
      alu_src              = src;
      cur_pc               = pc;
      read_data1           = a;
      read_data2           = b;
      sign_extended_output = im;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 2'b10, O_ADD, 1'b0, 64'h40, 64'd3, 64'd4, 64'd1);
      repeat (2) begin
         tick();
         tests_run++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
         end
         tests_run++;
         if (alu_result !== '0 || zero !== 1'b1 || branch_target !== '0 || store_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: res=%h zero=%b bt=%h sd=%h required 0 1 0 0",
                     alu_result, zero, branch_target, store_data);
         end
      end
      in_valid = 1'b0;
      reset    = 1'b1;
   endtask

   task automatic test_add_sub();
      out_ready = 1'b1;
      drive(1'b1, 2'b10, O_ADD, 1'b0, 64'h0, 64'd5, 64'd7, 64'd0);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL add_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || alu_result !== 64'd12 || zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_result: v=%b res=%h zero=%b required 1 c 0", out_valid, alu_result, zero);
      end
      drive(1'b1, 2'b10, O_SUB, 1'b0, 64'h0, 64'd9, 64'd9, 64'd0);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL sub_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || alu_result !== 64'd0 || zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL sub_result: v=%b res=%h zero=%b required 1 0 1", out_valid, alu_result, zero);
      end
      in_valid = 1'b0;
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_branch_pass();
      out_ready = 1'b1;
      drive(1'b1, 2'b01, O_ADD, 1'b0, 64'h100, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      tests_run++;
      if (branch_target !== 64'hF0 || alu_result !== 64'h0 || zero !== 1'b1 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL branch_neg: bt=%h res=%h zero=%b v=%b required f0 0 1 1",
                  branch_target, alu_result, zero, out_valid);
      end
      drive(1'b1, 2'b01, O_ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'hABCD, 64'd2);
      tick();
      tests_run++;
      if (branch_target !== 64'd4 || alu_result !== 64'hABCD || store_data !== 64'hABCD) begin
         tests_failed++;
         $display("FAIL branch_wrap: bt=%h res=%h sd=%h required 4 abcd abcd",
                  branch_target, alu_result, store_data);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      automatic int lat = 0;
      automatic logic [W-1:0] exp_res = model_result(2'b10, O_MUL, a, b);
      out_ready = 1'b1;
      drive(1'b1, 2'b10, O_MUL, 1'b0, 64'h2000, a, b, 64'h10);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready);
      end
      tick();
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tests_run++;
         if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL %s_stall: cycle %0d in_ready=%b required 0", name, lat, in_ready);
         end
         tick();
         lat++;
      end
      tests_run++;
      if (lat != 16) begin
         tests_failed++; $display("FAIL %s_latency: %0d cycles required 16", name, lat);
      end
      tests_run++;
      if (alu_result !== exp_res || zero !== (exp_res == '0) || branch_target !== 64'h2040
          || store_data !== b) begin
         tests_failed++;
         $display("FAIL %s_result: res=%h zero=%b bt=%h sd=%h required %h %b 2040 %h",
                  name, alu_result, zero, branch_target, store_data, exp_res, exp_res == '0, b);
      end
   endtask

   task automatic test_mul();
      run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, "mul_neg");
      run_mul(64'h1_0000_0000, 64'h1_0000_0000, "mul_wrap0");
      run_mul(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, "mul_big");
      tick();
   endtask

   task automatic test_backpressure();
      automatic logic [W-1:0] a1 = {$urandom, $urandom};
      automatic logic [W-1:0] b1 = {$urandom, $urandom};
      automatic logic [W-1:0] a2 = {$urandom, $urandom};
      automatic logic [W-1:0] b2 = {$urandom, $urandom};
      out_ready = 1'b0;
      drive(1'b1, 2'b10, O_ADD, 1'b0, 64'h500, a1, b1, 64'h3);
      tick();
      drive(1'b1, 2'b10, O_ADD, 1'b0, 64'h600, a2, b2, 64'h1);
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_result !== a1 + b1
             || branch_target !== 64'h50C || store_data !== b1) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: rdy=%b v=%b res=%h bt=%h required 0 1 %h 50c",
                     i, in_ready, out_valid, alu_result, branch_target, a1 + b1);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL bp_release: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || alu_result !== a2 + b2 || branch_target !== 64'h604) begin
         tests_failed++;
         $display("FAIL bp_next: v=%b res=%h bt=%h required 1 %h 604", out_valid, alu_result,
                  branch_target, a2 + b2);
      end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      automatic bit spurious = 0;
      out_ready = 1'b1;
      drive(1'b1, 2'b10, O_MUL, 1'b0, 64'h0, 64'd77, 64'd99, 64'd0);
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      reset = 1'b0;
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL midmul_reset: v=%b rdy=%b required 0 0", out_valid, in_ready);
      end
      reset = 1'b1;
      drive(1'b1, 2'b10, O_ADD, 1'b0, 64'h0, 64'd1, 64'd1, 64'd0);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL midmul_idle: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || alu_result !== 64'd2 || zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL midmul_add: v=%b res=%h zero=%b required 1 2 0", out_valid, alu_result, zero);
      end
      tick();
      repeat (20) begin
         if (out_valid !== 1'b0) spurious = 1;
         tick();
      end
      tests_run++;
      if (spurious) begin
         tests_failed++; $display("FAIL midmul_abort: out_valid seen 1 required 0");
      end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      automatic int  wait_cnt = 0;
      automatic bit  seen = 0;
      logic          exp_ready;
      logic [1:0]    aop;
      logic [10:0]   opc;
      logic [W-1:0]  a, b, im, pc, beff;
      logic          src;
      int            k;
      for (int i = 0; i < 1000; i++) begin
         if (out_valid === 1'b1) begin
            tests_run++;
            if (q.size() == 0) begin
               tests_failed++; $display("FAIL rand_spurious: out_valid=1 with nothing accepted");
            end else begin
               e = q[0];
               if (!seen) begin
                  seen = 1;
                  tests_run++;
                  if (wait_cnt != (e.is_mul ? 16 : 0)) begin
                     tests_failed++;
                     $display("FAIL rand_latency: waited %0d required %0d", wait_cnt, e.is_mul ? 16 : 0);
                  end
               end
               if (alu_result !== e.res || zero !== (e.res == '0) || branch_target !== e.bt
                   || store_data !== e.sd) begin
                  tests_failed++;
                  $display("FAIL rand_slot: res=%h zero=%b bt=%h sd=%h required %h %b %h %h",
                           alu_result, zero, branch_target, store_data, e.res, e.res == '0, e.bt, e.sd);
               end
            end
         end else if (q.size() != 0) begin
            wait_cnt++;
         end

         k   = $urandom_range(0, 8);
         aop = 2'b10;
         opc = $urandom;
         case (k)
            0: opc = O_ADD;
            1: opc = O_SUB;
            2: opc = O_AND;
            3: opc = O_ORR;
            4: opc = O_MUL;
            5: if (opc == O_ADD || opc == O_SUB || opc == O_AND || opc == O_ORR || opc == O_MUL)
                  opc = opc ^ 11'h001;
            6: aop = 2'b00;
            7: aop = 2'b01;
            default: aop = 2'b11;
         endcase
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         im  = {$urandom, $urandom};
         pc  = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
         end
         src = 1'(($urandom_range(0, 1)));
         if ($urandom_range(0, 5) == 0) begin
            b   = a;
            src = 1'b0;
         end
         beff = src ? im : b;
         if (i >= 900) begin
            drive(1'b0, aop, opc, src, pc, a, b, im);
            out_ready = 1'b1;
         end else begin
            drive($urandom_range(0, 3) != 0, aop, opc, src, pc, a, b, im);
            out_ready = ($urandom_range(0, 2) != 0);
         end
         #1;
         exp_ready = (q.size() == 0) ? 1'b1 : (out_valid ? out_ready : 1'b0);
         tests_run++;
         if (in_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL rand_ready: cycle %0d in_ready=%b required %b", i, in_ready, exp_ready);
         end
         if (out_valid === 1'b1 && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            seen     = 0;
            wait_cnt = 0;
         end
         if (in_valid && in_ready === 1'b1) begin
            e.res    = model_result(aop, opc, a, beff);
            e.bt     = model_target(pc, im);
            e.sd     = b;
            e.is_mul = (aop == 2'b10) && (opc == O_MUL);
            q.push_back(e);
         end
         tick();
      end
      tests_run++;
      if (q.size() != 0) begin
         tests_failed++; $display("FAIL rand_drain: %0d results never delivered required 0", q.size());
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      out_ready    = 1'b0;
      drive(1'b0, 2'b00, 11'd0, 1'b0, '0, '0, '0, '0);
      test_reset();
      test_add_sub();
      test_branch_pass();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised, registered successor to the LEGv8 execute stage.
- Sits between the ID/EX and EX/MEM boundaries. Computes the branch target, ALU result and zero flag, and registers them into an EX/MEM output slot.
- Adds valid/ready handshakes on both sides.
- Adds a multi-cycle iterative MUL, which stalls upstream while busy.

Parameters:
- WIDTH, 64, datapath width in bits (`WORD equivalent); must be ≥8 and a multiple of MUL_BITS.
- MUL_BITS, 4, multiplier bits retired per cycle; MUL occupancy = WIDTH/MUL_BITS cycles.
- MUL_EN, 1, 0 = MUL opcode decodes as ADD (no multiplier logic).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  ID/EX presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- cur_pc  in  WIDTH  PC of the instruction.
- read_data1  in  WIDTH  register operand A.
- read_data2  in  WIDTH  register operand B / store data.
- sign_extended_output  in  WIDTH  sign-extended immediate.
- alu_op  in  2  00 = add, 01 = pass B, 10 = R-type (decode opcode), 11 = reserved (treated as add).
- opcode  in  11  instruction opcode field.
- alu_src  in  1  0 = B is read_data2, 1 = B is the immediate.
- out_valid  out  1  EX/MEM slot holds a result.
- out_ready  in  1  downstream consumes the slot.
- branch_target  out  WIDTH  registered cur_pc + (imm << 2).
- alu_result  out  WIDTH  registered ALU/MUL result.
- zero  out  1  registered (alu_result == 0).
- store_data  out  WIDTH  registered read_data2.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state ← IDLE; out_valid ← 0.
  - branch_target, alu_result and store_data ← 0; zero ← 1.
  - Multiplier accumulator cleared.
  - Reset mid-MUL aborts the multiply; no result is emitted.
- ALU control (combinational from alu_op/opcode):
  - ADD 10001011000 → 0010 (add).
  - SUB 11001011000 → 0110 (sub).
  - AND 10001010000 → 0000.
  - ORR 10101010000 → 0001.
  - MUL 10011011000 → 1111 (mul).
  - Any other R-type opcode → add.
  - alu_op 01 → 0111 (pass B).
- Arithmetic: all arithmetic is modulo 2^WIDTH. Carry and overflow are dropped. MUL returns the low WIDTH bits of the unsigned product, which equals the signed low half.
- Branch target: cur_pc + (sign_extended_output << 2), truncated to WIDTH.
- Handshake:
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Inputs are sampled only on accept. Inputs are don't-care otherwise.
- State IDLE:
  - Accept of a non-MUL op: the output registers load next edge; out_valid ← 1. Latency is 1 cycle.
  - Accept of a MUL op (MUL_EN = 1): latch A, B, cur_pc, imm and store_data; go to MUL; counter ← WIDTH/MUL_BITS − 1.
  - Accept of a MUL op (MUL_EN = 0): handled as ADD.
  - out_valid && out_ready with no accept: out_valid ← 0.
  - Simultaneous consume and accept: the slot is overwritten and out_valid stays 1. Full throughput is 1 op/cycle.
- State MUL:
  - Each cycle, retire MUL_BITS of the multiplier (shift-add) and decrement the counter. in_ready = 0.
  - Counter == 0 and (!out_valid || out_ready): write the product to alu_result, compute zero, out_valid ← 1, go to IDLE. Latency is WIDTH/MUL_BITS cycles from accept to out_valid.
  - Counter == 0 with the slot full and not consumed: hold the product in MUL until the slot frees.
- Output slot stability: while out_valid && !out_ready, all outputs hold stable.
- zero is always consistent with the registered alu_result.

Decomposition:
- Shared package/header (definitions.vh):
  - ALU control codes (ALUC_AND, ALUC_ORR, ALUC_ADD, ALUC_SUB, ALUC_PASSB, ALUC_MUL).
  - R-type opcode constants.
  - State encoding (ST_IDLE, ST_MUL).
- One sub-module: iter_mul, the iterative shift-add multiplier with start/busy/done handshake, parametrised by WIDTH and MUL_BITS.
- ALU control decode and the ALU stay inline.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with in_valid = 1 → out_valid = 0, alu_result = 0, zero = 1, in_ready = 0 during reset.
- ADD then SUB back-to-back, out_ready = 1:
  - ADD A = 5, B = 7 → cycle+1 alu_result = 12, zero = 0.
  - SUB A = 9, B = 9 → next cycle alu_result = 0, zero = 1.
  - in_ready stays 1 throughout.
- Branch/pass:
  - alu_op = 01, cur_pc = 0x100, imm = −4 (all ones), read_data2 = 0 → branch_target = 0xF0, alu_result = 0, zero = 1.
  - cur_pc = 2^WIDTH−4, imm = 2 → branch_target = 4 (wrap-around).
- MUL, WIDTH = 64, MUL_BITS = 4: A = 0xFFFF_FFFF_FFFF_FFFF, B = 3 → in_ready = 0 for 16 cycles; out_valid rises 16 cycles after accept; alu_result = 0xFFFF_FFFF_FFFF_FFFD.
- Backpressure: out_ready = 0 with a result pending → in_ready = 0; outputs stable for 5 cycles; a new ADD is accepted in the cycle out_ready = 1 and appears the following cycle.
- Reset mid-MUL: assert reset at MUL cycle 7 → state IDLE, out_valid = 0; a subsequent ADD 1 + 1 yields 2 with 1-cycle latency.
